xg_tx_arbiter: RTL and testbench

XG_TX_ARBITER -- requirements
Module: xg_tx_arbiter

---
 rtl/xg_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_xg_tx_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xg_tx_arbiter.sv
// xg_tx_arbiter: packet-granular round-robin arbiter that merges NUM_PORTS
// AXI-Stream sources into one registered stream toward a 10G MAC.
// Optional build macro XG_TX_ARB_STAMP_EN: stamps a one-hot source-port code
// into m_axis_tuser[SRC_PORT_LSB +: 8]. Without it, tuser passes unmodified.
module xg_tx_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS          = 4,
    parameter int SRC_PORT_LSB       = 16
) (
    input  logic                                      axi_aclk,
    input  logic                                      axi_resetn,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
    output logic [NUM_PORTS-1:0]                      s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
    output logic                                      m_axis_tvalid,
    output logic                                      m_axis_tlast,
    input  logic                                      m_axis_tready,
    input  logic [NUM_PORTS-1:0]                      port_enable,
    output logic [NUM_PORTS-1:0]                      cur_grant
);

    localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {IDLE, PASS} state_t;

    state_t                        state;
    logic [IDX_W-1:0]              rr_ptr;
    logic [IDX_W-1:0]              grant_idx;
    logic [IDX_W-1:0]              pick_idx;
    logic [IDX_W-1:0]              cand;
    logic [IDX_W-1:0]              next_ptr;
    logic                          found;
    logic                          out_free;
    logic                          accept;
    logic [NUM_PORTS-1:0]          ready_vec;
    logic [C_AXIS_DATA_WIDTH-1:0]  sel_data;
    logic [KEEP_W-1:0]             sel_keep;
    logic [C_AXIS_TUSER_WIDTH-1:0] sel_user;
    logic [C_AXIS_TUSER_WIDTH-1:0] out_user;
    logic                          sel_last;

    // Output register can take a beat when empty or being drained this cycle.
    assign out_free = !m_axis_tvalid || m_axis_tready;

    // Only the granted port sees ready, and only while passing a packet.
    always_comb begin
        ready_vec = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            ready_vec[i] = (state == PASS) && cur_grant[i] && out_free;
        end
    end

    assign s_axis_tready = ready_vec;
    assign accept        = |(s_axis_tvalid & ready_vec);

    // Round-robin search: first valid, enabled port at or after rr_ptr.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned off = 0; off < NUM_PORTS; off++) begin
            cand = IDX_W'((int'(rr_ptr) + off) % NUM_PORTS);
            if (!found && s_axis_tvalid[cand] && port_enable[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign next_ptr = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;

    // Granted port's beat, selected by the registered grant index.
    assign sel_data = s_axis_tdata[grant_idx*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
    assign sel_keep = s_axis_tkeep[grant_idx*KEEP_W +: KEEP_W];
    assign sel_user = s_axis_tuser[grant_idx*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
    assign sel_last = s_axis_tlast[grant_idx];

`ifdef XG_TX_ARB_STAMP_EN
    // Overwrite the source-port byte with a one-hot code (ports 4+ get zero).
    always_comb begin
        out_user = sel_user;
        out_user[SRC_PORT_LSB +: 8] = (int'(grant_idx) < 4) ?
                                      8'(1 << (2 * int'(grant_idx))) : 8'h00;
    end
`else
    // Sideband passes through untouched.
    always_comb begin
        out_user = sel_user;
    end
`endif

    // Arbitration FSM: grant in IDLE, pass beats until the granted tlast.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            cur_grant <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        cur_grant <= NUM_PORTS'(1) << pick_idx;
                        grant_idx <= pick_idx;
                        state     <= PASS;
                    end
                end
                PASS: begin
                    if (accept && sel_last) begin
                        rr_ptr    <= next_ptr;
                        cur_grant <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output stage: load on accept, empty on downstream ready, else hold.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= sel_last;
            m_axis_tdata  <= sel_data;
            m_axis_tkeep  <= sel_keep;
            m_axis_tuser  <= out_user;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xg_tx_arbiter.sv
// Self-checking bench for xg_tx_arbiter (4 ports, 256-bit data, 128-bit tuser).
// Expected output streams come from a queue-based round-robin model.
module tb_xg_tx_arbiter;

    localparam int DW  = 256;
    localparam int KW  = DW / 8;
    localparam int UW  = 128;
    localparam int NP  = 4;
    localparam int SRC_LSB = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic              axi_aclk = 1'b0;
    logic              axi_resetn;
    logic [NP*DW-1:0]  s_axis_tdata;
    logic [NP*KW-1:0]  s_axis_tkeep;
    logic [NP*UW-1:0]  s_axis_tuser;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tlast;
    logic [NP-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [NP-1:0]     port_enable;
    logic [NP-1:0]     cur_grant;

    xg_tx_arbiter #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .NUM_PORTS         (NP),
        .SRC_PORT_LSB      (SRC_LSB)
    ) dut (
        .axi_aclk     (axi_aclk),
        .axi_resetn   (axi_resetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .port_enable  (port_enable),
        .cur_grant    (cur_grant)
    );

    initial forever #5 axi_aclk = ~axi_aclk;

    beat_t          src_q[NP][$];
    beat_t          ref_q[NP][$];
    beat_t          exp_q[$];
    beat_t          out_q[$];
    int             out_cyc[$];
    logic [NP-1:0]  grant_log[$];
    logic [NP-1:0]  last_grant = '0;
    logic [NP-1:0]  hs;
    int             cyc = 0;
    int             flush_req = 0;
    int             flush_ack = 0;
    int             errors = 0;
    int             checks = 0;

    // Source drivers and output monitor: sample at negedge, update at posedge+1.
    initial begin
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        forever begin
            @(negedge axi_aclk);
            hs = s_axis_tvalid & s_axis_tready;
            if (m_axis_tvalid && m_axis_tready) begin
                beat_t ob;
                ob.d = m_axis_tdata;
                ob.k = m_axis_tkeep;
                ob.u = m_axis_tuser;
                ob.l = m_axis_tlast;
                out_q.push_back(ob);
                out_cyc.push_back(cyc);
            end
            if (cur_grant != last_grant && cur_grant != '0) grant_log.push_back(cur_grant);
            last_grant = cur_grant;
            @(posedge axi_aclk);
            #1;
            cyc++;
            if (flush_req != flush_ack) begin
                for (int i = 0; i < NP; i++) src_q[i].delete();
                hs = '0;
                flush_ack = flush_req;
            end
            for (int i = 0; i < NP; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    s_axis_tvalid[i]          = 1'b1;
                    s_axis_tlast[i]           = src_q[i][0].l;
                    s_axis_tdata[i*DW +: DW]  = src_q[i][0].d;
                    s_axis_tkeep[i*KW +: KW]  = src_q[i][0].k;
                    s_axis_tuser[i*UW +: UW]  = src_q[i][0].u;
                end else begin
                    s_axis_tvalid[i]          = 1'b0;
                    s_axis_tlast[i]           = 1'b0;
                    s_axis_tdata[i*DW +: DW]  = '0;
                    s_axis_tkeep[i*KW +: KW]  = '0;
                    s_axis_tuser[i*UW +: UW]  = '0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge axi_aclk);
        #2;
    endtask

    task automatic sample;
        @(negedge axi_aclk);
        #1;
    endtask

    function automatic beat_t stamp(input beat_t b, input int p);
        beat_t r = b;
`ifdef XG_TX_ARB_STAMP_EN
        r.u[SRC_LSB +: 8] = (p < 4) ? 8'(1 << (2 * p)) : 8'h00;
`endif
        return r;
    endfunction

    // Model: all queued packets are visible at once; serve whole packets,
    // choosing the next non-empty port at or after the pointer each time.
    function automatic void build_expected();
        int    ptr = 0;
        int    p;
        bit    more = 1'b1;
        beat_t b;
        exp_q.delete();
        while (more) begin
            p = -1;
            for (int o = 0; o < NP; o++) begin
                int c = (ptr + o) % NP;
                if (p < 0 && ref_q[c].size() > 0) p = c;
            end
            if (p < 0) begin
                more = 1'b0;
            end else begin
                do begin
                    b = ref_q[p].pop_front();
                    exp_q.push_back(stamp(b, p));
                end while (!b.l && ref_q[p].size() > 0);
                ptr = (p + 1) % NP;
            end
        end
    endfunction

    task automatic add_pkt(input int p, input int len, input bit zero_user);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            for (int w = 0; w < DW / 32; w++) b.d[w*32 +: 32] = $urandom();
            b.k = $urandom();
            for (int w = 0; w < UW / 32; w++) b.u[w*32 +: 32] = zero_user ? 32'h0 : $urandom();
            b.l = (i == len - 1);
            src_q[p].push_back(b);
            ref_q[p].push_back(b);
        end
    endtask

    task automatic wait_out(input int n, output bit ok);
        for (int c = 0; c < 2000 && out_q.size() < n; c++) sample();
        ok = (out_q.size() >= n);
    endtask

    task automatic do_reset;
        tick();
        axi_resetn = 1'b0;
        flush_req++;
        tick();
        tick();
        axi_resetn = 1'b1;
        port_enable = '1;
        out_q.delete();
        out_cyc.delete();
        grant_log.delete();
        for (int i = 0; i < NP; i++) ref_q[i].delete();
    endtask

    task automatic test_reset;
        sample();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        checks++; if (m_axis_tuser !== '0 || m_axis_tkeep !== '0) begin errors++; $display("FAIL reset_tuser_tkeep: got %h/%h want 0", m_axis_tuser, m_axis_tkeep); end
        checks++; if (cur_grant !== '0) begin errors++; $display("FAIL reset_grant: got %b want 0000", cur_grant); end
        checks++; if (s_axis_tready !== '0) begin errors++; $display("FAIL reset_tready: got %b want 0000", s_axis_tready); end
        tick();
        axi_resetn = 1'b1;
        repeat (3) sample();
        checks++; if (cur_grant !== '0) begin errors++; $display("FAIL idle_grant: got %b want 0000", cur_grant); end
    endtask

    task automatic test_two_ports;
        bit ok;
        do_reset();
        m_axis_tready = 1'b1;
        add_pkt(0, 3, 1'b0);
        add_pkt(2, 3, 1'b0);
        build_expected();
        wait_out(exp_q.size(), ok);
        checks++; if (!ok) begin errors++; $display("FAIL two_ports_timeout: got %0d beats want %0d", out_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL two_ports_beat%0d: got %h want %h", k, out_q[k], exp_q[k]);
            end
        end
        checks++; if (grant_log.size() != 2) begin errors++; $display("FAIL two_ports_grants: got %0d grants want 2", grant_log.size()); end
        checks++; if (grant_log[0] !== 4'b0001) begin errors++; $display("FAIL two_ports_grant0: got %b want 0001", grant_log[0]); end
        checks++; if (grant_log[1] !== 4'b0100) begin errors++; $display("FAIL two_ports_grant1: got %b want 0100", grant_log[1]); end
    endtask

    task automatic test_round_robin;
        bit ok;
        do_reset();
        m_axis_tready = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) add_pkt(p, 1, 1'b0);
        build_expected();
        wait_out(exp_q.size(), ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_timeout: got %0d beats want %0d", out_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL rr_beat%0d: got %h want %h", k, out_q[k], exp_q[k]);
            end
        end
        for (int k = 1; k < out_q.size(); k++) begin
            checks++;
            if (out_cyc[k] - out_cyc[k-1] != 2) begin
                errors++; $display("FAIL rr_spacing%0d: got %0d cycles want 2", k, out_cyc[k] - out_cyc[k-1]);
            end
        end
    endtask

    task automatic test_stall;
        bit ok;
        do_reset();
        m_axis_tready = 1'b1;
        add_pkt(0, 4, 1'b0);
        build_expected();
        for (int c = 0; c < 200 && out_q.size() < 2; c++) sample();
        tick();
        m_axis_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            sample();
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_q[2].d || m_axis_tlast !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d: got v=%b l=%b d=%h want v=1 l=0 d=%h", c, m_axis_tvalid, m_axis_tlast, m_axis_tdata, exp_q[2].d);
            end
            checks++;
            if (s_axis_tready !== '0) begin errors++; $display("FAIL stall_tready%0d: got %b want 0000", c, s_axis_tready); end
        end
        tick();
        m_axis_tready = 1'b1;
        wait_out(4, ok);
        repeat (6) sample();
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL stall_count: got %0d beats want 4", out_q.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_q[k] !== exp_q[k]) begin errors++; $display("FAIL stall_beat%0d: got %h want %h", k, out_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_enable;
        bit ok;
        do_reset();
        m_axis_tready = 1'b1;
        add_pkt(1, 4, 1'b0);
        build_expected();
        for (int c = 0; c < 200 && out_q.size() < 1; c++) sample();
        tick();
        port_enable = 4'b1101;
        wait_out(4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL enable_timeout: got %0d beats want 4", out_q.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_q[k] !== exp_q[k]) begin errors++; $display("FAIL enable_beat%0d: got %h want %h", k, out_q[k], exp_q[k]); end
        end
        add_pkt(1, 2, 1'b0);
        for (int c = 0; c < 20; c++) begin
            sample();
            checks++;
            if (cur_grant !== '0) begin errors++; $display("FAIL enable_nogrant%0d: got %b want 0000", c, cur_grant); end
        end
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL enable_extra: got %0d beats want 4", out_q.size()); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        do_reset();
        m_axis_tready = 1'b1;
        add_pkt(0, 1, 1'b0);
        wait_out(1, ok);
        add_pkt(1, 4, 1'b0);
        for (int c = 0; c < 200 && out_q.size() < 2; c++) sample();
        tick();
        axi_resetn = 1'b0;
        flush_req++;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0 || m_axis_tuser !== '0 || m_axis_tkeep !== '0) begin
            errors++; $display("FAIL midreset_out: got v=%b l=%b d=%h want all 0", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        checks++;
        if (cur_grant !== '0 || s_axis_tready !== '0) begin
            errors++; $display("FAIL midreset_grant: got grant=%b tready=%b want 0000/0000", cur_grant, s_axis_tready);
        end
        tick();
        tick();
        axi_resetn = 1'b1;
        out_q.delete();
        out_cyc.delete();
        grant_log.delete();
        for (int i = 0; i < NP; i++) ref_q[i].delete();
        add_pkt(1, 1, 1'b0);
        add_pkt(0, 1, 1'b0);
        build_expected();
        wait_out(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midreset_timeout: got %0d beats want 2", out_q.size()); end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (out_q[k] !== exp_q[k]) begin errors++; $display("FAIL midreset_beat%0d: got %h want %h", k, out_q[k], exp_q[k]); end
        end
        checks++; if (grant_log[0] !== 4'b0001) begin errors++; $display("FAIL midreset_first_grant: got %b want 0001", grant_log[0]); end
    endtask

    task automatic test_stamp;
        bit ok;
        logic [UW-1:0] exp_u;
        exp_u = '0;
`ifdef XG_TX_ARB_STAMP_EN
        exp_u[23:16] = 8'h04;
`endif
        do_reset();
        m_axis_tready = 1'b1;
        add_pkt(1, 2, 1'b1);
        wait_out(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stamp_timeout: got %0d beats want 2", out_q.size()); end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (out_q[k].u !== exp_u) begin errors++; $display("FAIL stamp_tuser%0d: got %h want %h", k, out_q[k].u, exp_u); end
        end
    endtask

    task automatic test_random;
        bit done = 1'b0;
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < NP; p++) add_pkt(p, $urandom_range(1, 5), 1'b0);
        build_expected();
        for (int c = 0; c < 3000 && !done; c++) begin
            tick();
            m_axis_tready = ($urandom_range(0, 3) != 0);
            done = (out_q.size() >= exp_q.size());
        end
        m_axis_tready = 1'b1;
        repeat (4) sample();
        checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d beats want %0d", out_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL random_beat%0d: got %h want %h", k, out_q[k], exp_q[k]);
            end
        end
    endtask

    initial begin
        axi_resetn    = 1'b0;
        m_axis_tready = 1'b0;
        port_enable   = '1;
        test_reset();
        test_two_ports();
        test_round_robin();
        test_stall();
        test_enable();
        test_reset_mid();
        test_stamp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
